// File: rtl/cpu_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_isa_pkg
// Description : Shared ISA definitions: opcode values, the fetch FSM state
//               encoding and the instruction-length decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_isa_pkg;

  // Opcode values (instruction word value of the first word)
  localparam int unsigned OP_NOP   = 0;
  localparam int unsigned OP_LDAC  = 7;
  localparam int unsigned OP_STAC  = 11;
  localparam int unsigned OP_MVACR = 15;
  localparam int unsigned OP_MVR   = 17;
  localparam int unsigned OP_ADD   = 19;
  localparam int unsigned OP_ADDM  = 21;
  localparam int unsigned OP_INAC  = 24;
  localparam int unsigned OP_SUB   = 25;
  localparam int unsigned OP_MUL   = 27;
  localparam int unsigned OP_MULM  = 29;
  localparam int unsigned OP_CLAC  = 32;
  localparam int unsigned OP_JUMP  = 33;
  localparam int unsigned OP_JPNZ  = 35;
  localparam int unsigned OP_ENDOP = 40;
  localparam int unsigned OP_LDA   = 45;
  localparam int unsigned OP_LDB   = 51;
  localparam int unsigned OP_LDC   = 57;
  localparam int unsigned OP_MVA   = 59;
  localparam int unsigned OP_MVB   = 60;
  localparam int unsigned OP_MVC   = 61;
  localparam int unsigned OP_MVACC = 62;
  localparam int unsigned OP_STC   = 63;

  // Fetch FSM states
  typedef enum logic [2:0] {
    S_ADDR_OP  = 3'd0,
    S_DATA_OP  = 3'd1,
    S_ADDR_ARG = 3'd2,
    S_DATA_ARG = 3'd3,
    S_PRESENT  = 3'd4,
    S_HALT     = 3'd5
  } fetch_state_e;

  // True for opcodes that carry an operand word; undefined codes are one-word
  function automatic logic is_two_word(input logic [31:0] opcode);
    case (opcode)
      OP_LDAC, OP_STAC, OP_JUMP, OP_JPNZ,
      OP_LDA,  OP_LDB,  OP_LDC,  OP_STC:  is_two_word = 1'b1;
      default:                            is_two_word = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches one- and two-word instructions from a one-cycle
//               latency IRAM, presents them over valid/ready, follows jump
//               redirects and stops after ENDOP is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] START_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic              instr_has_operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_iram_addr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [DATA_W-1:0] r_opcode;
  logic [DATA_W-1:0] r_operand;
  logic              r_has_operand;
  logic              r_valid;
  logic              r_halted;

  logic              w_handshake;
  logic              w_is_endop;
  logic              w_data_two_word;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_pc_step;
  logic              w_take_redirect;
  logic              w_ld_opcode;
  logic              w_ld_operand;
  logic              w_advance;

  assign w_handshake     = r_valid & instr_ready;
  assign w_is_endop      = (r_opcode == DATA_W'(OP_ENDOP));
  assign w_data_two_word = is_two_word(32'(iram_data));
  // Wraps naturally modulo 2^ADDR_W
  assign w_pc_plus1      = r_pc + ADDR_W'(1);
  assign w_pc_step       = r_pc + (r_has_operand ? ADDR_W'(2) : ADDR_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ADDR_OP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a redirect overrides everything except HALT
  always_comb begin
    w_state_nxt = r_state;
    if (r_state != S_HALT && redirect) begin
      w_state_nxt = S_ADDR_OP;
    end else begin
      case (r_state)
        S_ADDR_OP:  w_state_nxt = S_DATA_OP;
        S_DATA_OP:  w_state_nxt = w_data_two_word ? S_ADDR_ARG : S_PRESENT;
        S_ADDR_ARG: w_state_nxt = S_DATA_ARG;
        S_DATA_ARG: w_state_nxt = S_PRESENT;
        S_PRESENT: begin
          if (w_handshake) begin
            w_state_nxt = w_is_endop ? S_HALT : S_ADDR_OP;
          end
        end
        S_HALT:     w_state_nxt = S_HALT;
        default:    w_state_nxt = S_ADDR_OP;
      endcase
    end
  end

  // Datapath control decoded from the current state
  always_comb begin
    w_take_redirect = 1'b0;
    w_ld_opcode     = 1'b0;
    w_ld_operand    = 1'b0;
    w_advance       = 1'b0;
    if (r_state != S_HALT && redirect) begin
      w_take_redirect = 1'b1;
    end else begin
      case (r_state)
        S_DATA_OP:  w_ld_opcode  = 1'b1;
        S_DATA_ARG: w_ld_operand = 1'b1;
        // ENDOP leaves PC and IRAM address frozen at the ENDOP word
        S_PRESENT:  w_advance    = w_handshake & ~w_is_endop;
        default:    ;
      endcase
    end
  end

  // PC, IRAM address and instruction registers; valid/halted are registered
  // from the next state so nothing combinational reaches the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= START_PC;
      r_iram_addr   <= START_PC;
      r_instr_pc    <= '0;
      r_opcode      <= '0;
      r_operand     <= '0;
      r_has_operand <= 1'b0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_valid  <= (w_state_nxt == S_PRESENT);
      r_halted <= (w_state_nxt == S_HALT);
      if (w_take_redirect) begin
        r_pc        <= redirect_pc;
        r_iram_addr <= redirect_pc;
      end else if (w_ld_opcode) begin
        r_opcode      <= iram_data;
        r_instr_pc    <= r_pc;
        r_has_operand <= w_data_two_word;
        if (w_data_two_word) begin
          r_iram_addr <= w_pc_plus1;
        end else begin
          r_operand <= '0;
        end
      end else if (w_ld_operand) begin
        r_operand <= iram_data;
      end else if (w_advance) begin
        r_pc        <= w_pc_step;
        r_iram_addr <= w_pc_step;
      end
    end
  end

  assign iram_addr         = r_iram_addr;
  assign instr_valid       = r_valid;
  assign instr_opcode      = r_opcode;
  assign instr_operand     = r_operand;
  assign instr_has_operand = r_has_operand;
  assign instr_pc          = r_instr_pc;
  assign halted            = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A transaction-level
//               model walks instruction memory and predicts what is presented,
//               when, and where the IRAM address points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [15:0] START = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] iram_addr;
  logic [15:0] iram_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_opcode;
  logic [15:0] instr_operand;
  logic        instr_has_operand;
  logic [15:0] instr_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  logic [15:0] mem [0:65535];

  logic [15:0] m_pc;
  bit          m_halted;
  int          m_wait;
  int          n_checks = 0;
  int          n_errors = 0;

  instr_fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .START_PC (START)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .iram_addr         (iram_addr),
    .iram_data         (iram_data),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr_opcode      (instr_opcode),
    .instr_operand     (instr_operand),
    .instr_has_operand (instr_has_operand),
    .instr_pc          (instr_pc),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .halted            (halted)
  );

  always #5 clk = ~clk;

  // IRAM: one-cycle read latency
  always @(posedge clk) iram_data <= mem[iram_addr];

  function automatic bit ref_two(input logic [15:0] w);
    return (w == 16'd7)  || (w == 16'd11) || (w == 16'd33) || (w == 16'd35) ||
           (w == 16'd45) || (w == 16'd51) || (w == 16'd57) || (w == 16'd63);
  endfunction

  // Cycles from entering opcode fetch until the instruction is presented
  function automatic int ref_lat(input logic [15:0] pc);
    return ref_two(mem[pc]) ? 4 : 2;
  endfunction

  function automatic logic [15:0] pick_two(input int k);
    case (k)
      0: return 16'd7;   1: return 16'd11;  2: return 16'd33;  3: return 16'd35;
      4: return 16'd45;  5: return 16'd51;  6: return 16'd57;  default: return 16'd63;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit          ev;
    logic [15:0] p1;
    ev = !m_halted && (m_wait == 0);
    p1 = m_pc + 16'd1;
    check("valid",  32'(instr_valid), 32'(ev));
    check("halted", 32'(halted),      32'(m_halted));
    if (ev) begin
      check("opcode",      32'(instr_opcode),      32'(mem[m_pc]));
      check("has_operand", 32'(instr_has_operand), 32'(ref_two(mem[m_pc])));
      check("operand",     32'(instr_operand),     32'(ref_two(mem[m_pc]) ? mem[p1] : 16'd0));
      check("instr_pc",    32'(instr_pc),          32'(m_pc));
    end
    if (m_halted)
      check("addr_frozen", 32'(iram_addr), 32'(m_pc));
    else if (m_wait == ref_lat(m_pc))
      check("addr_op", 32'(iram_addr), 32'(m_pc));
    else if (m_wait == 2 && ref_two(mem[m_pc]))
      check("addr_arg", 32'(iram_addr), 32'(p1));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check
  task automatic step(input bit rdy, input bit rdr, input logic [15:0] rpc);
    bit hs;
    instr_ready = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    hs = !m_halted && (m_wait == 0) && rdy;
    if (!m_halted) begin
      if (rdr) begin
        m_pc   = rpc;
        m_wait = ref_lat(rpc);
      end else if (hs) begin
        if (mem[m_pc] == 16'd40) begin
          m_halted = 1'b1;
        end else begin
          m_pc   = m_pc + (ref_two(mem[m_pc]) ? 16'd2 : 16'd1);
          m_wait = ref_lat(m_pc);
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_addr",     32'(iram_addr),         32'(START));
    check("rst_valid",    32'(instr_valid),       32'd0);
    check("rst_opcode",   32'(instr_opcode),      32'd0);
    check("rst_operand",  32'(instr_operand),     32'd0);
    check("rst_has",      32'(instr_has_operand), 32'd0);
    check("rst_instr_pc", 32'(instr_pc),          32'd0);
    check("rst_halted",   32'(halted),            32'd0);
    rst_n    = 1'b1;
    m_pc     = START;
    m_halted = 1'b0;
    m_wait   = ref_lat(START);
  endtask

  // Assert reset between clock edges and check outputs clear without an edge
  task automatic async_reset_check();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid",  32'(instr_valid), 32'd0);
    check("async_addr",   32'(iram_addr),   32'(START));
    check("async_halted", 32'(halted),      32'd0);
    check("async_pc",     32'(instr_pc),    32'd0);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!instr_valid && k < 8) begin
      step(1'b0, 1'b0, 16'h0);
      k++;
    end
    check("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;

    // CLAC then STAC 6 with ready held high
    clear_mem();
    mem[0] = 16'd32; mem[1] = 16'd11; mem[2] = 16'd6;
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h0);

    // Backpressure on LDAC 8
    clear_mem();
    mem[0] = 16'd7; mem[1] = 16'd8;
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 16'h0);

    // Redirect together with the handshake of JPNZ at 63
    clear_mem();
    mem[63] = 16'd35; mem[64] = 16'd1234; mem[65] = 16'h00AA; mem[10] = 16'd32;
    do_reset();
    step(1'b0, 1'b1, 16'd63);
    wait_valid();
    step(1'b1, 1'b1, 16'd10);
    wait_valid();
    check("redir_pc", 32'(instr_pc), 32'd10);
    step(1'b1, 1'b0, 16'h0);

    // Redirect while the LDAC operand is being fetched
    clear_mem();
    mem[0] = 16'd7; mem[1] = 16'd99; mem[20] = 16'd24;
    do_reset();
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'd20);
    wait_valid();
    step(1'b1, 1'b0, 16'h0);

    // ENDOP at 94, redirects ignored, reset recovers
    clear_mem();
    mem[94] = 16'd40;
    do_reset();
    step(1'b0, 1'b1, 16'd94);
    wait_valid();
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'($urandom));
    async_reset_check();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0);

    // Two-word instruction straddling the top of memory
    clear_mem();
    mem[16'hFFFF] = 16'd45; mem[0] = 16'd9; mem[1] = 16'd32;
    do_reset();
    step(1'b0, 1'b1, 16'hFFFF);
    wait_valid();
    step(1'b1, 1'b0, 16'h0);
    wait_valid();
    check("wrap_pc", 32'(instr_pc), 32'd1);
    step(1'b1, 1'b0, 16'h0);

    // Random program, ready and redirects
    for (int i = 0; i < 65536; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 30)      mem[i] = pick_two(int'($urandom_range(0, 7)));
      else if (r < 32) mem[i] = 16'd40;
      else             mem[i] = 16'($urandom);
    end
    do_reset();
    begin
      int halt_cnt;
      halt_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
        bit          rdy;
        bit          rdr;
        logic [15:0] rpc;
        rdy = ($urandom_range(0, 9) < 7);
        rdr = ($urandom_range(0, 39) == 0);
        rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
        step(rdy, rdr, rpc);
        if (m_halted) halt_cnt++;
        if (halt_cnt > 3) begin
          async_reset_check();
          do_reset();
          halt_cnt = 0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage between the 16-bit instruction RAM and the core control unit. Drives the IRAM read address and captures the one-cycle-latency read data. Assembles one-word and two-word (opcode + operand) instructions and presents each to the control unit over a valid/ready handshake. Handles PC redirects from jumps and stops fetching after ENDOP.

## Interface
- `ADDR_W`, default 16: PC and IRAM address width.
- `DATA_W`, default 16: instruction word width.
- `START_PC`, default 0: PC value after reset.

- `clk`, in, 1: clock, all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `iram_addr`, out, ADDR_W: registered IRAM read address.
- `iram_data`, in, DATA_W: IRAM read data, valid the cycle after `iram_addr` is sampled by IRAM.
- `instr_valid`, out, 1: an instruction is presented.
- `instr_ready`, in, 1: control unit accepts the instruction when asserted with `instr_valid`.
- `instr_opcode`, out, DATA_W: opcode word.
- `instr_operand`, out, DATA_W: operand word; 0 for one-word instructions.
- `instr_has_operand`, out, 1: instruction is two-word.
- `instr_pc`, out, ADDR_W: address of the opcode word.
- `redirect`, in, 1: jump taken; discard in-flight fetch.
- `redirect_pc`, in, ADDR_W: new PC when `redirect`=1.
- `halted`, out, 1: ENDOP accepted; fetching stopped.

## Operation
- Two-word opcodes: LDAC=7, STAC=11, JUMP=33, JPNZ=35, LDA=45, LDB=51, LDC=57, STC=63.
- All other values are one-word, including undefined codes. ENDOP=40.
- FSM states: ADDR_OP, DATA_OP, ADDR_ARG, DATA_ARG, PRESENT, HALT.
- ADDR_OP: `iram_addr`=pc. Next state is DATA_OP.
- DATA_OP: latch `iram_data` into opcode and record `instr_pc`=pc.
  - Two-word: `iram_addr`<=pc+1, go to ADDR_ARG.
  - One-word: operand<=0, go to PRESENT.
- ADDR_ARG: go to DATA_ARG.
- DATA_ARG: latch `iram_data` into operand, go to PRESENT.
- PRESENT: `instr_valid`=1. All `instr_*` outputs are held stable until the handshake.
  - On handshake: pc<=pc+1 (one-word) or pc+2 (two-word); `iram_addr` follows; go to ADDR_OP.
  - If the accepted opcode is ENDOP: go to HALT instead.
- HALT: `halted`=1, `instr_valid`=0, `iram_addr` frozen. Only `rst_n` exits HALT.
- Redirect, in any state except HALT:
  - pc<=`redirect_pc`, `iram_addr`<=`redirect_pc`, `instr_valid`<=0, go to ADDR_OP.
  - The partially assembled instruction is discarded.
- Redirect in the same cycle as a handshake: the handshake completes for the control unit; the PC update and next state come from the redirect.
- Redirect in HALT is ignored.
- PC arithmetic is modulo 2^ADDR_W. 0xFFFF+1 gives 0x0000. A two-word instruction at 0xFFFF takes its operand from 0x0000.

## Timing
- Reset values: `iram_addr`=START_PC, `instr_valid`=0, `instr_opcode`=0, `instr_operand`=0, `instr_has_operand`=0, `instr_pc`=0, `halted`=0. Reset state is ADDR_OP.
- Reset asserted mid-instruction returns everything to the reset values immediately, without waiting for a clock edge.
- Latency from entering ADDR_OP to `instr_valid`=1: 2 cycles (one-word), 4 cycles (two-word).
- Throughput with `instr_ready` held at 1: one-word every 3 cycles, two-word every 5 cycles.
- `instr_valid` never drops without a handshake, except on redirect or reset.
- `instr_valid` is registered, with no combinational path from `instr_ready`.
- `halted` rises on the cycle after the ENDOP handshake.

## Structure
- Shared package `cpu_isa_pkg` holds:
  - opcode constants (NOP, LDAC, STAC, MVACR, MVR, ADD, ADDM, INAC, SUB, MUL, MULM, CLAC, JUMP, JPNZ, ENDOP, LDA, LDB, LDC, MVA, MVB, MVC, MVACC, STC);
  - the FSM state enum;
  - function `is_two_word(opcode)`.
- No sub-module. The block is one FSM plus PC and output registers.

## Test plan
- Reset release with IRAM[0]=CLAC(32), IRAM[1]=STAC(11), IRAM[2]=6, ready=1 -> CLAC valid at cycle 2 (pc 0, has_operand=0, operand=0); STAC presented with operand 6 and pc 1, 5 cycles later.
- Backpressure: ready=0 for 10 cycles while LDAC/8 is presented -> valid, opcode 7, operand 8 and pc stay stable; pc advances by 2 only on the handshake.
- Redirect: JPNZ at pc 63, redirect_pc=10 asserted during PRESENT together with the handshake -> next `iram_addr`=10; next instruction presented has pc 10; no instruction from pc 65 ever appears.
- Redirect during ADDR_ARG of LDAC -> partial instruction dropped, `instr_valid` stays 0, fetch restarts at `redirect_pc`.
- ENDOP(40) at pc 94 accepted -> `halted`=1 next cycle, `iram_addr` frozen at 94, valid stays 0, redirect ignored; reset restores START_PC and `halted`=0.
- Wrap: redirect to 0xFFFF where IRAM[0xFFFF]=LDA(45) and IRAM[0]=9 -> operand 9, next pc 0x0001.
